// File: rtl/rl_ram_1r1w_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rl_ram_1r1w_ctrl
// Brief    : Clear/arbitrate/forward controller for a 1R1W RAM. It clears the
//            array, round-robins two write requesters and forwards same-cycle
//            writes to the 1-cycle read.
// Revision : 1.0 - initial release
// ============================================================================
module rl_ram_1r1w_ctrl #(
    parameter int ABITS   = 10,
    parameter int DBITS   = 32,
    parameter int INIT_EN = 1,
    localparam int BEBITS = (DBITS + 7) / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              init_req_i,
    output logic              busy_o,
    input  logic              w0_req_i,
    input  logic [ABITS-1:0]  w0_addr_i,
    input  logic [DBITS-1:0]  w0_data_i,
    input  logic [BEBITS-1:0] w0_be_i,
    output logic              w0_ack_o,
    input  logic              w1_req_i,
    input  logic [ABITS-1:0]  w1_addr_i,
    input  logic [DBITS-1:0]  w1_data_i,
    input  logic [BEBITS-1:0] w1_be_i,
    output logic              w1_ack_o,
    input  logic              rd_req_i,
    input  logic [ABITS-1:0]  rd_addr_i,
    output logic              rd_valid_o,
    output logic [DBITS-1:0]  rd_data_o,
    output logic [ABITS-1:0]  mem_waddr_o,
    output logic [DBITS-1:0]  mem_din_o,
    output logic              mem_we_o,
    output logic [BEBITS-1:0] mem_be_o,
    output logic [ABITS-1:0]  mem_raddr_o,
    input  logic [DBITS-1:0]  mem_dout_i
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ABITS-1:0] c_CNT_MAX = {ABITS{1'b1}};
    localparam state_t           c_RST_ST  = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ABITS-1:0]   r_cnt;
    logic [ABITS-1:0]   w_cnt_nxt;
    logic               r_rr;
    logic               r_rd_valid;
    logic               r_fwd_hit;
    logic [DBITS-1:0]   r_fwd_data;
    logic [BEBITS-1:0]  r_fwd_be;

    logic               w_run;
    logic               w_gnt_valid;
    logic               w_gnt_idx;
    logic               w_rd_acc;
    logic               w_fwd_hit;
    logic [DBITS-1:0]   w_rd_data;

    // Outputs that matter to the RAM and requesters are gated by reset directly,
    // so they are safe even before the first clock edge of a reset pulse.
    assign w_run       = rst_ni && (r_state == ST_RUN);
    assign w_gnt_valid = w_run && (w0_req_i || w1_req_i);
    assign w_gnt_idx   = (w0_req_i && w1_req_i) ? r_rr : w1_req_i;
    assign w_rd_acc    = w_run && rd_req_i;
    assign w_fwd_hit   = w_rd_acc && w_gnt_valid && (mem_waddr_o == rd_addr_i);

    assign mem_raddr_o = rd_addr_i;
    assign rd_valid_o  = r_rd_valid;
    assign rd_data_o   = w_rd_data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= c_RST_ST;
            r_cnt      <= '0;
            r_rr       <= 1'b0;
            r_rd_valid <= 1'b0;
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
            r_fwd_be   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_valid <= w_rd_acc;
            r_fwd_hit  <= w_fwd_hit;
            r_fwd_data <= mem_din_o;
            r_fwd_be   <= mem_be_o;
            if (w_gnt_valid) begin
                r_rr <= ~w_gnt_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        busy_o      = 1'b0;
        mem_we_o    = 1'b0;
        mem_waddr_o = w0_addr_i;
        mem_din_o   = w0_data_i;
        mem_be_o    = w0_be_i;
        w0_ack_o    = 1'b0;
        w1_ack_o    = 1'b0;

        if (!rst_ni) begin
            busy_o = (INIT_EN != 0);
        end else begin
            case (r_state)
                ST_INIT: begin
                    busy_o      = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_waddr_o = r_cnt;
                    mem_din_o   = '0;
                    mem_be_o    = '1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == c_CNT_MAX) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    if (w_gnt_valid) begin
                        mem_we_o = 1'b1;
                        if (w_gnt_idx) begin
                            mem_waddr_o = w1_addr_i;
                            mem_din_o   = w1_data_i;
                            mem_be_o    = w1_be_i;
                            w1_ack_o    = 1'b1;
                        end else begin
                            w0_ack_o    = 1'b1;
                        end
                    end
                    if (init_req_i) begin
                        w_state_nxt = ST_INIT;
                        w_cnt_nxt   = '0;
                    end
                end
            endcase
        end
    end

    // The top lane may be narrower than 8 bits when DBITS is not byte aligned.
    for (genvar k = 0; k < BEBITS; k++) begin : g_byte
        localparam int LO = 8 * k;
        localparam int HI = ((8 * k + 7) < DBITS) ? (8 * k + 7) : (DBITS - 1);
        assign w_rd_data[HI:LO] = (r_fwd_hit && r_fwd_be[k]) ? r_fwd_data[HI:LO]
                                                             : mem_dout_i[HI:LO];
    end

endmodule
`default_nettype wire

// File: tb/tb_rl_ram_1r1w_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rl_ram_1r1w_ctrl
// Brief    : Directed self-checking bench with a behavioural 1R1W RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rl_ram_1r1w_ctrl;

    localparam int ABITS  = 4;
    localparam int DBITS  = 32;
    localparam int BEBITS = 4;

    logic              clk;
    logic              rst_n;
    logic              init_req;
    logic              busy;
    logic              w0_req, w1_req, w0_ack, w1_ack;
    logic [ABITS-1:0]  w0_addr, w1_addr;
    logic [DBITS-1:0]  w0_data, w1_data;
    logic [BEBITS-1:0] w0_be, w1_be;
    logic              rd_req, rd_valid;
    logic [ABITS-1:0]  rd_addr;
    logic [DBITS-1:0]  rd_data;
    logic [ABITS-1:0]  mem_waddr, mem_raddr;
    logic [DBITS-1:0]  mem_din, mem_dout;
    logic              mem_we;
    logic [BEBITS-1:0] mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    rl_ram_1r1w_ctrl #(.ABITS(ABITS), .DBITS(DBITS), .INIT_EN(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .busy_o(busy),
        .w0_req_i(w0_req), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
        .w0_be_i(w0_be), .w0_ack_o(w0_ack),
        .w1_req_i(w1_req), .w1_addr_i(w1_addr), .w1_data_i(w1_data),
        .w1_be_i(w1_be), .w1_ack_o(w1_ack),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid),
        .rd_data_o(rd_data),
        .mem_waddr_o(mem_waddr), .mem_din_o(mem_din), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_raddr_o(mem_raddr), .mem_dout_i(mem_dout)
    );

    // RAM model: registered read returning old data on a same-address write.
    logic [DBITS-1:0] ram [1 << ABITS];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BEBITS; b++) begin
                if (mem_be[b]) ram[mem_waddr][8*b +: 8] <= mem_din[8*b +: 8];
            end
        end
        mem_dout <= ram[mem_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; init_req = 1'b0;
        w0_req = 1'b1; w0_addr = '0; w0_data = '0; w0_be = '1;
        w1_req = 1'b1; w1_addr = '0; w1_data = '0; w1_be = '1;
        rd_req = 1'b0; rd_addr = '0;
        tick(); tick();
        #1;
        check("rst_busy", busy, 1);
        check("rst_we", mem_we, 0);
        check("rst_ack0", w0_ack, 0);
        check("rst_ack1", w1_ack, 0);
        check("rst_rdv", rd_valid, 0);

        // Initial clear: 16 cycles writing zeros to 0..15
        w0_req = 1'b0; w1_req = 1'b0;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check("init_busy", busy, 1);
            check("init_we", mem_we, 1);
            check("init_waddr", mem_waddr, i);
            check("init_din", mem_din, 0);
            check("init_be", mem_be, 4'hF);
            tick();
        end
        check("run_busy", busy, 0);

        // Read back all 16 addresses back-to-back
        for (int i = 0; i < 16; i++) begin
            rd_req = 1'b1; rd_addr = 4'(i);
            tick();
            check("clr_rdv", rd_valid, 1);
            check("clr_rdata", rd_data, 0);
        end
        rd_req = 1'b0;
        tick();
        check("rdv_idle", rd_valid, 0);

        // Both requesters held: alternate starting with w0
        w0_req = 1'b1; w0_addr = 4'd1; w0_be = 4'hF;
        w1_req = 1'b1; w1_addr = 4'd2; w1_be = 4'hF;
        for (int k = 0; k < 6; k++) begin
            w0_data = 32'h100 + k; w1_data = 32'h200 + k;
            #1;
            check("rr_ack0", w0_ack, (k % 2) == 0);
            check("rr_ack1", w1_ack, (k % 2) == 1);
            check("rr_din", mem_din, ((k % 2) == 0) ? 32'h100 + k : 32'h200 + k);
            tick();
        end
        w0_req = 1'b0;
        w1_data = 32'h2AA;
        #1;
        check("lone_ack1", w1_ack, 1);
        check("lone_waddr", mem_waddr, 2);
        tick();
        w0_req = 1'b1;
        #1;
        check("after_lone_ack0", w0_ack, 1);
        check("after_lone_ack1", w1_ack, 0);
        tick();
        w0_req = 1'b0; w1_req = 1'b0;

        // Same-cycle write/read collision with partial byte enables
        w0_req = 1'b1; w0_addr = 4'd5; w0_data = 32'h11223344; w0_be = 4'hF;
        tick();
        w0_data = 32'hAABBCCDD; w0_be = 4'b0101;
        rd_req = 1'b1; rd_addr = 4'd5;
        #1;
        check("fwd_ack", w0_ack, 1);
        tick();
        w0_req = 1'b0;
        check("fwd_rdv", rd_valid, 1);
        check("fwd_rdata", rd_data, 32'h11BB33DD);
        tick();
        rd_req = 1'b0;
        check("fwd_follow", rd_data, 32'h11BB33DD);

        // Write then read one cycle later needs no forwarding
        w0_req = 1'b1; w0_addr = 4'd3; w0_data = 32'hCAFEF00D; w0_be = 4'hF;
        tick();
        w0_req = 1'b0;
        rd_req = 1'b1; rd_addr = 4'd3;
        tick();
        rd_req = 1'b0;
        check("wr_rd_rdv", rd_valid, 1);
        check("wr_rd_data", rd_data, 32'hCAFEF00D);

        // Clear on request while a read is accepted the same cycle
        init_req = 1'b1; rd_req = 1'b1; rd_addr = 4'd3;
        #1;
        check("ireq_busy", busy, 0);
        tick();
        init_req = 1'b0;
        w0_req = 1'b1; w0_addr = 4'd7; w0_data = 32'h77; w0_be = 4'hF;
        check("ireq_rdv", rd_valid, 1);
        check("ireq_rdata", rd_data, 32'hCAFEF00D);
        for (int i = 0; i < 16; i++) begin
            #1;
            check("reinit_busy", busy, 1);
            check("reinit_ack", w0_ack, 0);
            check("reinit_waddr", mem_waddr, i);
            check("reinit_din", mem_din, 0);
            if (i > 0) check("reinit_rdv", rd_valid, 0);
            tick();
        end
        rd_req = 1'b0;
        #1;
        check("reinit_done", busy, 0);
        check("pend_ack", w0_ack, 1);
        check("pend_din", mem_din, 32'h77);
        tick();
        w0_req = 1'b0;
        rd_req = 1'b1; rd_addr = 4'd3;
        tick();
        check("clr3", rd_data, 0);
        rd_addr = 4'd5;
        tick();
        check("clr5", rd_data, 0);
        rd_addr = 4'd7;
        tick();
        rd_req = 1'b0;
        check("pend7", rd_data, 32'h77);

        // Reset pulse during clear at counter 9
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            check("pre_waddr", mem_waddr, i);
            tick();
        end
        check("at9_waddr", mem_waddr, 9);
        rst_n = 1'b0;
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_busy", busy, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("restart_busy", busy, 1);
            check("restart_waddr", mem_waddr, i);
            tick();
        end
        check("restart_done", busy, 0);
        rd_req = 1'b1; rd_addr = 4'd7;
        tick();
        rd_req = 1'b0;
        check("restart_rdata", rd_data, 0);
        check("restart_rdv", rd_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rl_ram_1r1w_ctrl.md
Name: rl_ram_1r1w_ctrl

Overview:
Controller in front of one rl_ram_1r1w_generic instance. Clears the array after reset or on request. Shares the single write port between two write requesters with round-robin arbitration. Serves one read requester with 1-cycle latency, and adds write-to-read forwarding, because the RAM itself returns old data on a same-address collision.

Parameters:
ABITS, 10, RAM address width; depth = 2**ABITS
DBITS, 32, RAM data width
INIT_EN, 1, 1 = clear the whole array after reset; 0 = go straight to RUN
BEBITS (local), (DBITS+7)/8, byte-enable width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous and active-low
init_req_i  in  1  pulse: restart array clear (ignored while busy_o=1)
busy_o  out  1  clear in progress
w0_req_i  in  1  requester 0 write request; hold until ack
w0_addr_i  in  ABITS  requester 0 write address
w0_data_i  in  DBITS  requester 0 write data
w0_be_i  in  BEBITS  requester 0 byte enables
w0_ack_o  out  1  requester 0 write performed this cycle
w1_req_i / w1_addr_i / w1_data_i / w1_be_i / w1_ack_o  same as requester 0, for requester 1
rd_req_i  in  1  read request (no backpressure)
rd_addr_i  in  ABITS  read address
rd_valid_o  out  1  rd_data_o valid
rd_data_o  out  DBITS  read data
mem_waddr_o  out  ABITS  to RAM waddr_i
mem_din_o  out  DBITS  to RAM din_i
mem_we_o  out  1  to RAM we_i
mem_be_o  out  BEBITS  to RAM be_i
mem_raddr_o  out  ABITS  to RAM raddr_i
mem_dout_i  in  DBITS  from RAM dout_o

Behaviour:
- Reset (rst_ni=0 at a clk edge):
  - State = INIT if INIT_EN else RUN; clear counter = 0; RR pointer = 0; rd_valid_o = 0; forward flag = 0.
  - While reset is held: busy_o = INIT_EN; mem_we_o = 0; all acks = 0.
- FSM states INIT and RUN.
- INIT:
  - Each cycle: mem_we_o = 1, mem_waddr_o = counter, mem_din_o = 0, mem_be_o = all ones; counter increments.
  - At counter = 2**ABITS-1, write the last word and move to RUN next cycle. busy_o = 1 for exactly 2**ABITS cycles.
  - No acks; rd_req_i ignored; rd_valid_o = 0.
- RUN:
  - busy_o = 0.
  - init_req_i = 1: INIT next cycle with counter = 0. In that cycle normal arbitration and reads still occur.
  - Asserting rst_ni=0 mid-INIT restarts the clear from address 0.
- Write arbitration (RUN only), combinational grant:
  - Only w0 requesting: grant 0. Only w1: grant 1. Both: grant = RR pointer. Neither: mem_we_o = 0.
  - Granted requester's addr/data/be drive mem_*; mem_we_o = 1; its ack_o = 1 in the same cycle.
  - After any grant, the pointer is set to the non-granted index (w0 -> 1, w1 -> 0).
  - Requesters keep request fields stable until acked. At most one ack per cycle; acks never asserted outside RUN.
- Read (RUN only):
  - mem_raddr_o = rd_addr_i combinationally; accepted every cycle rd_req_i = 1.
  - rd_valid_o = 1 exactly one cycle after acceptance, with rd_data_o for that cycle.
  - Back-to-back reads yield valid on consecutive cycles.
- Forwarding:
  - If a write is granted in the same cycle as an accepted read to the same address, register hit, data and be.
  - Next cycle, rd_data_o byte k = write byte k if be[k], else mem_dout_i byte k.
  - A write to address A in cycle N followed by a read of A in cycle N+1 needs no forwarding (RAM already updated).
  - Read accepted in the cycle init_req_i is seen still completes normally.
- Partial top byte when DBITS is not a multiple of 8: the top be bit covers bits DBITS-1 : 8*(BEBITS-1), both for writes and for forwarding.

Test Plan:
- ABITS=4, INIT_EN=1, release reset -> busy_o high for 16 cycles, mem_we_o=1 with waddr 0..15, din=0, be=all ones; then reading all 16 addresses returns 0 with rd_valid_o one cycle after each request.
- w0_req_i and w1_req_i both held high for 6 cycles with distinct data -> acks alternate w0, w1, w0, w1, w0, w1; a lone w1 request followed by both requesting grants w0 next.
- Addr 5 holds 0x11223344; same cycle write addr 5, data 0xAABBCCDD, be 4'b0101, and read addr 5 -> next cycle rd_valid_o=1, rd_data_o=0x11BB33DD; a follow-up read returns 0x11BB33DD from the RAM.
- Write addr 3 = 0xCAFEF00D in cycle N, read addr 3 in cycle N+1 -> rd_data_o=0xCAFEF00D at N+2, no forward flag set.
- init_req_i pulse in RUN after writing nonzero data -> busy_o high 16 cycles, pending w0_req_i gets no ack until RUN returns, subsequent reads return 0.
- rst_ni=0 for one cycle during INIT at counter=9 -> clearing restarts at address 0, busy_o high a full 16 cycles after release.
